// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM/grant encodings and defaults for the memory port arbiter
package mem_port_arbiter_pkg;
    localparam int WORD_SIZE_DEF = 16;
    localparam int CNT_W = 3;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;
endpackage

// File: rtl/mem_port_arbiter_prio.sv
// port_priority_sel: data side wins a tie unless the instruction side has hit its starvation limit
module port_priority_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output gnt_t             grant
);
    assign grant = (d_req && !(i_req && starve_cnt == CNT_W'(STARVE_LIMIT))) ? GNT_D : GNT_I;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between instruction and data requesters
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE    = WORD_SIZE_DEF,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_done,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_done,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);

    state_t           state;
    gnt_t             grant;
    gnt_t             sel;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] starve_cnt;
    logic             d_wr;

    port_priority_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt),
        .grant      (sel)
    );

    assign d_wr = sel == GNT_D && d_we;

    // The memory strobes and address/data are the transaction latches themselves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= GNT_I;
            cnt        <= '0;
            starve_cnt <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: if (i_req || d_req) begin
                    state     <= ACCESS;
                    grant     <= sel;
                    cnt       <= CNT_LOAD;
                    mem_read  <= !d_wr;
                    mem_write <= d_wr;
                    mem_addr  <= sel == GNT_D ? d_addr : i_addr;
                    mem_wdata <= d_wr ? d_wdata : '0;
                    if (sel == GNT_I)
                        starve_cnt <= '0;
                    else if (i_req && starve_cnt != LIMIT)
                        starve_cnt <= starve_cnt + 1'b1;
                end
                ACCESS: if (cnt == '0) begin
                    state     <= RESP;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    mem_wdata <= '0;
                    i_done    <= grant == GNT_I;
                    d_done    <= grant == GNT_D;
                    if (mem_read && grant == GNT_I) i_rdata <= mem_rdata;
                    if (mem_read && grant == GNT_D) d_rdata <= mem_rdata;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: begin
                    state  <= IDLE;
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the memory port arbiter and its latency variants
module tb_mem_port_arbiter;
    localparam int W   = 16;
    localparam int LAT = 2;

    typedef struct {
        logic         side;
        logic [W-1:0] rdata;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [W-1:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic         i_done, d_done, mem_read, mem_write;
    logic [W-1:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic         l_req = 1'b0;
    logic [W-1:0] l_addr = 16'h0033;
    logic         a1_id, a1_dd, a1_mr, a1_mw, a7_id, a7_dd, a7_mr, a7_mw;
    logic [W-1:0] a1_ir, a1_dr, a1_ma, a1_mwd, a7_ir, a7_dr, a7_ma, a7_mwd;

    int           tests = 0;
    int           fails = 0;
    exp_t         exp_q[$];
    exp_t         e;
    logic [W-1:0] mi = '0, md = '0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rdata_of(input logic [W-1:0] a);
        return a == 16'h0010 ? 16'hB000 : a ^ 16'h5A5A;
    endfunction

    assign mem_rdata = mem_read ? rdata_of(mem_addr) : '0;

    mem_port_arbiter #(.WORD_SIZE(W), .LATENCY(LAT), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.WORD_SIZE(W), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .i_req(l_req), .i_addr(l_addr), .i_done(a1_id), .i_rdata(a1_ir),
        .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
        .d_done(a1_dd), .d_rdata(a1_dr),
        .mem_read(a1_mr), .mem_write(a1_mw), .mem_addr(a1_ma),
        .mem_wdata(a1_mwd), .mem_rdata(rdata_of(a1_ma))
    );

    mem_port_arbiter #(.WORD_SIZE(W), .LATENCY(7)) dut_l7 (
        .clk(clk), .reset(reset),
        .i_req(l_req), .i_addr(l_addr), .i_done(a7_id), .i_rdata(a7_ir),
        .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
        .d_done(a7_dd), .d_rdata(a7_dr),
        .mem_read(a7_mr), .mem_write(a7_mw), .mem_addr(a7_ma),
        .mem_wdata(a7_mwd), .mem_rdata(rdata_of(a7_ma))
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        chk("excl", 32'(mem_read & mem_write), 0);
        if (!mem_read && !mem_write) chk("wdata_idle", mem_wdata, 0);
        if (i_done || d_done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", {i_done, d_done}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("done_side", {i_done, d_done}, e.side ? 2'b01 : 2'b10);
                chk("rdata", e.side ? d_rdata : i_rdata, e.rdata);
            end
        end
    end

    // n counts cycles inclusively, starting with the cycle the request is first seen in IDLE
    task automatic xact(input logic side, input logic we, input logic [W-1:0] addr,
                        input logic [W-1:0] wdata, input logic drop);
        int   n = 1, strobes = 0, bad = 0;
        exp_t x;
        if (!we) begin
            if (side) md = rdata_of(addr);
            else mi = rdata_of(addr);
        end
        x.side  = side;
        x.rdata = side ? md : mi;
        exp_q.push_back(x);
        if (side) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        do begin
            @(posedge clk); #1;
            n++;
            if (mem_read || mem_write) begin
                strobes++;
                if (mem_addr !== addr || mem_read !== !we || mem_wdata !== (we ? wdata : 16'h0)) bad++;
                if (side) begin
                    d_addr = ~addr; d_wdata = ~wdata;
                    if (drop) d_req = 1'b0;
                end else begin
                    i_addr = ~addr;
                end
            end
        end while (!(i_done || d_done) && n < 21);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        chk("latency", n, LAT + 2);
        chk("strobe_cycles", strobes, LAT);
        chk("mem_values", bad, 0);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_access();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0077;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("read_before_reset", mem_read, 1);
        reset = 1'b1;
        #1;
        chk("strobes_on_reset", {mem_read, mem_write}, 0);
        d_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("drdata_after_reset", d_rdata, 0);
        mi = '0; md = '0;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic starve();
        exp_t x;
        int   n = 0;
        for (int k = 0; k < 8; k++) begin
            x.side  = (k % 4) != 3;
            x.rdata = rdata_of(x.side ? 16'h0200 : 16'h0100);
            exp_q.push_back(x);
        end
        md = rdata_of(16'h0200);
        mi = rdata_of(16'h0100);
        i_req = 1'b1; i_addr = 16'h0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("starve_pending", exp_q.size(), 0);
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic latency_variants();
        int n = 1, got1 = 0, got7 = 0;
        l_req = 1'b1;
        while (n < 14 && (got1 == 0 || got7 == 0)) begin
            @(posedge clk); #1;
            n++;
            if (a1_id && got1 == 0) got1 = n;
            if (a7_id && got7 == 0) got7 = n;
        end
        l_req = 1'b0;
        chk("latency_l1", got1, 3);
        chk("latency_l7", got7, 9);
        chk("rdata_l1", a1_ir, rdata_of(l_addr));
        chk("rdata_l7", a7_ir, rdata_of(l_addr));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {i_done, d_done, mem_read, mem_write}, 0);
        chk("reset_rdata", {i_rdata, d_rdata}, 0);
        chk("reset_mem", {mem_addr, mem_wdata}, 0);
        @(negedge clk) reset = 1'b0;
        xact(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
        chk("i_rdata_b000", i_rdata, 16'hB000);
        xact(1'b1, 1'b1, 16'h0040, 16'h1234, 1'b0);
        xact(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
        xact(1'b1, 1'b1, 16'h0055, 16'hBEEF, 1'b0);
        xact(1'b1, 1'b0, 16'h0099, 16'h0000, 1'b1);
        xact(1'b0, 1'b0, 16'h0123, 16'h0000, 1'b0);
        @(posedge clk); #1;
        chk("mem_addr_hold", mem_addr, 16'h0123);
        reset_mid_access();
        xact(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
        starve();
        latency_variants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
